// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC and sequences I-cache requests.
// Redirects take a one-cycle flush bubble. Decode hazards and cache misses hold the PC.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'd1000,
    parameter logic [31:0] EXC_VECTOR = 32'd8192
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hazard_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_exc_valid,
    output logic        o_ic_req,
    output logic [31:0] o_ic_addr,
    input  logic        i_ic_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_next_pc,
    output logic        o_if_valid,
    output logic        o_flush,
    output logic [31:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_MISS_WAIT,
        S_REDIRECT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_stall_cycles;
    logic        r_ic_req;
    logic        r_flush;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_if_valid;
    logic        w_stall;
    logic [31:0] w_next_pc;

    // An exception outranks a branch. A branch target is forced to word alignment.
    assign w_redirect    = i_exc_valid | i_br_taken;
    assign w_redirect_pc = i_exc_valid ? EXC_VECTOR : (i_br_target & ~32'd3);
    assign w_if_valid    = r_ic_req & i_ic_ready & ~i_hazard_stall & ~w_redirect;
    assign w_stall       = r_ic_req & ~w_if_valid;
    assign w_next_pc     = r_pc + 32'd4;

    // NOTE: state and outputs are assigned with non-blocking assignments, so every
    // decision in this block uses the values from before the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_stall_cycles <= '0;
            r_ic_req       <= 1'b0;
            r_flush        <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end

            case (r_state)
                S_BOOT: begin
                    r_state  <= S_FETCH;
                    r_ic_req <= 1'b1;
                    r_flush  <= 1'b0;
                end
                S_FETCH, S_MISS_WAIT: begin
                    if (w_redirect) begin
                        r_pc     <= w_redirect_pc;
                        r_state  <= S_REDIRECT;
                        r_ic_req <= 1'b0;
                        r_flush  <= 1'b1;
                    end else if (i_hazard_stall) begin
                        r_state <= S_FETCH;
                    end else if (!i_ic_ready) begin
                        r_state <= S_MISS_WAIT;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_REDIRECT: begin
                    // A back-to-back redirect replaces the target and extends the bubble.
                    if (w_redirect) begin
                        r_pc <= w_redirect_pc;
                    end else begin
                        r_state  <= S_FETCH;
                        r_ic_req <= 1'b1;
                        r_flush  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_BOOT;
                    r_ic_req <= 1'b0;
                    r_flush  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ic_req       = r_ic_req;
    assign o_ic_addr      = r_pc;
    assign o_pc           = r_pc;
    assign o_next_pc      = w_next_pc;
    assign o_if_valid     = w_if_valid;
    assign o_flush        = r_flush;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch against the instruction cache. Arbitrates the PC-update sources (reset, exception, branch redirect, hazard stall, cache miss) under fixed priority, drives the I-cache request handshake, and hands valid fetch slots to the IF/ID latch with a flush pulse on every redirect. Sits between the hazard/branch logic of the pipeline and the I-cache.

## Interface

- RESET_PC, 32'd1000, first fetch address after reset
- EXC_VECTOR, 32'd8192, fetch address on exception

- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- hazard_stall  in  1  decode hazard: hold PC, do not issue fetch slot
- br_taken  in  1  branch/jump redirect from execute
- br_target  in  32  redirect address (bits [1:0] ignored, forced to 00)
- exc_valid  in  1  exception redirect to EXC_VECTOR
- ic_req  out  1  fetch request to I-cache
- ic_addr  out  32  fetch address (equals PC)
- ic_ready  in  1  instruction for ic_addr returned this cycle
- PC  out  32  current fetch PC
- next_PC  out  32  PC + 4 (mod 2^32), combinational
- if_valid  out  1  fetched instruction accepted into IF/ID this cycle
- flush  out  1  kill younger pipeline contents, one-cycle pulse
- stall_cycles  out  32  count of requested-but-not-accepted fetch cycles

## Operation

- States: BOOT, FETCH, MISS_WAIT, REDIRECT.
- Reset (sampled at edge): state=BOOT, PC=RESET_PC, stall_cycles=0. Outputs while in BOOT: ic_req=0, if_valid=0, flush=0, ic_addr=PC=1000, next_PC=1004. BOOT -> FETCH unconditionally.
- Priority each cycle (non-BOOT states): exc_valid > br_taken > hazard_stall > ic miss > sequential advance.
- Redirect (exc_valid or br_taken sampled high in FETCH, MISS_WAIT or REDIRECT): PC <= EXC_VECTOR or {br_target[31:2],2'b00}; state <= REDIRECT. Redirect while already in REDIRECT overrides PC and stays in REDIRECT.
- REDIRECT: ic_req=0, if_valid=0, flush=1. Next state FETCH unless new redirect.
- FETCH / MISS_WAIT: ic_req=1, ic_addr=PC.
  - if_valid = ic_ready & !hazard_stall & !exc_valid & !br_taken.
  - if_valid=1: PC <= PC+4, state <= FETCH.
  - ic_ready=1 with hazard_stall=1: PC held, state FETCH (same address re-requested).
  - ic_ready=0, no redirect: PC held, state <= MISS_WAIT.
- Handshake: while ic_req=1 and ic_ready=0, ic_addr is stable. ic_req dropping (REDIRECT) cancels any outstanding miss; cache must discard it.
- stall_cycles increments in any cycle with ic_req=1 and if_valid=0; saturates at 32'hFFFFFFFF.
- Arithmetic: PC and next_PC 32-bit, wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).

## Timing

- Reset released at edge E0: BOOT during cycle after E0; first ic_req at cycle after E1; first if_valid earliest that same cycle (ic_ready=1).
- Sequential throughput: one fetch per cycle with ic_ready=1, no stall.
- Redirect penalty: redirect sampled at edge N -> cycle N+1 REDIRECT (flush=1, PC=target) -> cycle N+2 ic_req with ic_addr=target.
- Wrong-path fetch in redirect cycle suppressed (if_valid=0 even with ic_ready=1).
- Reset mid-miss or mid-redirect: next cycle BOOT, ic_req=0, counter cleared, pending miss abandoned.

## Test plan

- Reset, ic_ready=1 constant, no stalls -> ic_addr 1000, 1004, 1008 on consecutive cycles, if_valid=1 each, stall_cycles=0.
- Miss: ic_ready=0 for 3 cycles at PC=1008 -> ic_addr held 1008, state MISS_WAIT, if_valid=0, stall_cycles=3, then accept and PC=1012.
- br_taken, br_target=32'h203, with hazard_stall=1 -> next cycle flush=1, ic_req=0, PC=32'h200; following cycle ic_addr=32'h200; no if_valid in redirect cycles.
- exc_valid and br_taken (target 32'h400) same cycle during miss -> PC=8192, one flush pulse, miss cancelled, next fetch 8192.
- br_target=32'hFFFFFFFC, ic_ready=1 -> fetch at 32'hFFFFFFFC with next_PC=0, then fetch at 0.
- Assert reset during MISS_WAIT with stall_cycles=5 -> BOOT, stall_cycles=0, PC=1000, ic_req=0 for one cycle, fetch resumes at 1000.
